// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin arbiter sharing the single write port
// of the 32x32 register bank among NREQ valid/ready requesters.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   req_valid  per-requester write request
//   req_dr     packed destination registers, slice i = [i*ADDR_W +: ADDR_W]
//   req_data   packed write data, slice i = [i*DATA_W +: DATA_W]
//   req_ready  one-hot (or zero) acceptance, combinational
//   dr         registered bank write address
//   wrData     registered bank write data
//   write      registered bank write enable
//   grant_id   requester that caused the current write
//   busy       high while the post-reset clear sweep runs
//
// Optional feature: define REGFILE_ARB_CLEAR_EN to zero every register
// after reset, before any requester is served.

module regfile_write_arbiter #(
    parameter int NREQ   = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*ADDR_W-1:0]   req_dr,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic [ADDR_W-1:0]        dr,
    output logic [DATA_W-1:0]        wrData,
    output logic                     write,
    output logic [2:0]               grant_id,
    output logic                     busy
);

    logic              write_q, write_d;
    logic [ADDR_W-1:0] dr_q, dr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [2:0]        grant_id_q, grant_id_d;
    logic [2:0]        rr_ptr_q, rr_ptr_d;

    logic              arb_en;
    logic              win_valid;
    logic [2:0]        win_idx;
    logic [2:0]        win_off;
    logic [3:0]        win_sum;
    logic [3:0]        nxt_ptr;
    logic [NREQ-1:0]   rot_valid;
    logic [ADDR_W-1:0] sel_dr;
    logic [DATA_W-1:0] sel_data;
    logic              xfer;

`ifdef REGFILE_ARB_CLEAR_EN
    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    assign arb_en = (state_q == S_RUN);
    assign busy   = (state_q == S_CLEAR);
`else
    assign arb_en = 1'b1;
    assign busy   = 1'b0;
`endif

    // Rotate the request vector so bit 0 is the requester at rr_ptr; the
    // lowest set bit of the rotated vector is the round-robin winner.
    always_comb begin
        rot_valid = NREQ'(({req_valid, req_valid} >> rr_ptr_q));
        win_valid = 1'b0;
        win_off   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot_valid[k]) begin
                win_valid = 1'b1;
                win_off   = 3'(k);
            end
        end
        win_sum = 4'(rr_ptr_q) + 4'(win_off);
        if (win_sum >= 4'(NREQ)) begin
            win_idx = 3'(win_sum - 4'(NREQ));
        end else begin
            win_idx = 3'(win_sum);
        end
        nxt_ptr = 4'(win_idx) + 4'd1;
    end

    assign sel_dr   = ADDR_W'(req_dr >> (int'(win_idx) * ADDR_W));
    assign sel_data = DATA_W'(req_data >> (int'(win_idx) * DATA_W));

    // Ready is suppressed during reset so no handshake completes on an
    // edge whose effects the reset discards anyway.
    always_comb begin
        req_ready = '0;
        if (arb_en && win_valid && !reset) begin
            req_ready = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
        end
    end

    assign xfer = arb_en && win_valid;

    always_comb begin
        write_d    = 1'b0;
        dr_d       = dr_q;
        wr_data_d  = wr_data_q;
        grant_id_d = grant_id_q;
        rr_ptr_d   = rr_ptr_q;
`ifdef REGFILE_ARB_CLEAR_EN
        state_d    = state_q;
        cnt_d      = cnt_q;
        if (state_q == S_CLEAR) begin
            write_d   = 1'b1;
            dr_d      = cnt_q;
            wr_data_d = '0;
            cnt_d     = cnt_q + 1'b1;
            if (&cnt_q) begin
                state_d = S_RUN;
            end
        end
`endif
        if (xfer) begin
            write_d    = 1'b1;
            dr_d       = sel_dr;
            wr_data_d  = sel_data;
            grant_id_d = win_idx;
            if (nxt_ptr >= 4'(NREQ)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = 3'(nxt_ptr);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            write_q    <= 1'b0;
            dr_q       <= '0;
            wr_data_q  <= '0;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
`ifdef REGFILE_ARB_CLEAR_EN
            state_q    <= S_CLEAR;
            cnt_q      <= '0;
`endif
        end else begin
            write_q    <= write_d;
            dr_q       <= dr_d;
            wr_data_q  <= wr_data_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
`ifdef REGFILE_ARB_CLEAR_EN
            state_q    <= state_d;
            cnt_q      <= cnt_d;
`endif
        end
    end

    assign write    = write_q;
    assign dr       = dr_q;
    assign wrData   = wr_data_q;
    assign grant_id = grant_id_q;

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single write port of the 32x32 register bank (`regbank`) among NREQ independent requesters using per-requester valid/ready handshakes and round-robin priority.
- Drives the bank's `dr`, `wrData` and `write` inputs from registered outputs.
- Optionally runs a post-reset clear sweep that zeroes all registers before any requester is served.
- Sits between the execution/load units and `regbank`.

Parameters:
- NREQ, 4, number of write requesters (2..8).
- DATA_W, 32, write data width; matches the bank word.
- ADDR_W, 5, register address width; the bank depth is 2**ADDR_W.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  bit i set: requester i presents a write.
- req_dr  input  NREQ*ADDR_W  destination register; requester i occupies slice [i*ADDR_W +: ADDR_W].
- req_data  input  NREQ*DATA_W  write data; requester i occupies slice [i*DATA_W +: DATA_W].
- req_ready  output  NREQ  one-hot or zero; bit i set: requester i is accepted this cycle.
- dr  output  ADDR_W  bank write address (registered).
- wrData  output  DATA_W  bank write data (registered).
- write  output  1  bank write enable (registered).
- grant_id  output  3  index of the requester that caused the current `write`.
- busy  output  1  high while the clear sweep runs; always 0 when the sweep is compiled out.

Behaviour:
- **Reset values:** write=0, dr=0, wrData=0, grant_id=0, rr_ptr=0, req_ready=0.
  - With the optional feature compiled in: state=CLEAR, sweep counter=0, busy=1.
  - Without it: state=RUN, busy=0.
- **FSM states:** CLEAR and RUN.
  - CLEAR exists only when the macro is defined.
  - CLEAR -> RUN after the last sweep write.
  - RUN has no exit except reset.
- **Arbitration in RUN:**
  - The winner is the first requester with req_valid set, searching from rr_ptr upward modulo NREQ.
  - req_ready is combinational from req_valid and rr_ptr; only the winner's bit is set.
  - If no requester is valid, req_ready=0.
- **Transfer:** occurs when req_valid[i] and req_ready[i] are both 1 at a clock edge.
- **Latency:** on the next cycle, write=1, dr=req_dr slice i, wrData=req_data slice i, grant_id=i.
  - Latency is exactly 1 cycle from acceptance to bank write.
  - Sustained throughput is 1 write per cycle.
- **Pointer update:** after a transfer by requester i, rr_ptr <= (i+1) mod NREQ. With no transfer, rr_ptr holds.
- **Idle cycle:** with no transfer, the next cycle has write=0. dr, wrData and grant_id hold their previous values.
- **Requester obligations:** a requester keeps req_valid, req_dr and req_data stable until it sees req_ready. The arbiter never drops an accepted request.
- **Same-address requests:** two requesters targeting the same dr in one cycle are not a special case. They are served in round-robin order, so the later grant's data is what remains in the register.
- **Fairness:** with all NREQ requesters continuously valid, each is granted exactly once per NREQ cycles.
- **Mid-operation reset:** reset in any cycle forces the reset values on the next edge. A write already registered for that edge is cancelled (write=0). In-flight handshakes are discarded.

Optional Feature:
- Macro: REGFILE_ARB_CLEAR_EN.
- **Defined:**
  - After reset deasserts, the block spends 2**ADDR_W cycles in CLEAR.
  - Each cycle it drives write=1, dr=counter, wrData=0 and increments the counter.
  - During CLEAR: req_ready=0 and busy=1.
  - After the write with dr=2**ADDR_W-1, the block enters RUN; busy=0 in the following cycle and arbitration begins in that cycle.
  - Reset asserted during CLEAR restarts the sweep at register 0.
- **Undefined:**
  - No CLEAR state; busy is tied to 0.
  - Requests are accepted in the first cycle after reset deasserts.

Test Plan:
- **Single requester:** reset for 1 cycle; req_valid=0001, req_dr[0]=7, req_data[0]=70 -> req_ready=0001 the same cycle; next cycle write=1, dr=7, wrData=70, grant_id=0; bank reg[7] reads 70.
- **Round robin:** all four requesters held valid (dr=1,2,3,4; data=10,20,30,40) for 8 cycles -> grant_id sequence 0,1,2,3,0,1,2,3 with write=1 every cycle.
- **Pointer after partial traffic:** grant req1, then only req0 and req3 valid -> req3 is granted before req0.
- **Same-address requests:** req0 and req2 both valid with dr=5, data 100 and 200, rr_ptr=0 -> req0 written first, then req2; reg[5] finally reads 200.
- **Clear sweep** (REGFILE_ARB_CLEAR_EN): preload bank with nonzero values, pulse reset -> busy=1 and req_ready=0 for 32 cycles; write=1 with dr=0..31 and wrData=0; then busy=0; all 32 registers read 0.
- **Mid-operation reset:** assert reset while req1 is valid and a write is pending -> next cycle write=0, rr_ptr=0, and (with the macro defined) the sweep restarts at dr=0.
